// File: rtl/rab_inv_walker_if.sv
// Request and L2-table access bundle for the RAB invalidation walker.
// The walker connects through the slave modport; the requester/table side uses master.
interface rab_inv_walker_if #(
   parameter int N_PORTS   = 2,
   parameter int N_SETS    = 32,
   parameter int N_ENTRIES = 32,
   parameter int VA_WIDTH  = 32,
   parameter int PAGE_BITS = 12
);
   localparam int VW = VA_WIDTH - PAGE_BITS;
   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int SW = (N_SETS > 1) ? $clog2(N_SETS) : 1;
   localparam int EW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int CW = $clog2(N_SETS * N_ENTRIES + 1);

   logic                req_valid_i;
   logic                req_ready_o;
   logic [PW-1:0]       req_port_i;
   logic                req_all_i;
   logic [VA_WIDTH-1:0] req_va_start_i;
   logic [VA_WIDTH-1:0] req_va_end_i;
   logic                busy_o;
   logic                done_o;
   logic [CW-1:0]       inv_count_o;
   logic                tbl_rd_en_o;
   logic                tbl_wr_en_o;
   logic [PW-1:0]       tbl_port_o;
   logic [SW-1:0]       tbl_set_o;
   logic [EW-1:0]       tbl_entry_o;
   logic                tbl_gnt_i;
   logic                tbl_rd_valid_i;
   logic [VW-1:0]       tbl_rd_vpn_i;

   modport slave (
      input  req_valid_i, req_port_i, req_all_i, req_va_start_i, req_va_end_i,
      input  tbl_gnt_i, tbl_rd_valid_i, tbl_rd_vpn_i,
      output req_ready_o, busy_o, done_o, inv_count_o,
      output tbl_rd_en_o, tbl_wr_en_o, tbl_port_o, tbl_set_o, tbl_entry_o
   );

   modport master (
      output req_valid_i, req_port_i, req_all_i, req_va_start_i, req_va_end_i,
      output tbl_gnt_i, tbl_rd_valid_i, tbl_rd_vpn_i,
      input  req_ready_o, busy_o, done_o, inv_count_o,
      input  tbl_rd_en_o, tbl_wr_en_o, tbl_port_o, tbl_set_o, tbl_entry_o
   );
endinterface

// File: rtl/rab_inv_walker.sv
// RAB L2 TLB invalidation walker: sweeps every set/entry of one port's table
// and clears the valid bit of entries whose VPN is in range (or all, on flush).
module rab_inv_walker #(
   parameter int N_PORTS   = 2,
   parameter int N_SETS    = 32,
   parameter int N_ENTRIES = 32,
   parameter int VA_WIDTH  = 32,
   parameter int PAGE_BITS = 12
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   rab_inv_walker_if.slave bus
);
   localparam int VW = VA_WIDTH - PAGE_BITS;
   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int SW = (N_SETS > 1) ? $clog2(N_SETS) : 1;
   localparam int EW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int CW = $clog2(N_SETS * N_ENTRIES + 1);

   localparam logic [SW-1:0] LAST_SET   = SW'(N_SETS - 1);
   localparam logic [EW-1:0] LAST_ENTRY = EW'(N_ENTRIES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_CLEAR = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    r_state;
   logic [PW-1:0] r_port;
   logic          r_all;
   logic [VW-1:0] r_start_vpn;
   logic [VW-1:0] r_end_vpn;
   logic [SW-1:0] r_set;
   logic [EW-1:0] r_entry;
   logic [CW-1:0] r_count;

   logic [VW-1:0] w_req_start_vpn;
   logic [VW-1:0] w_req_end_vpn;
   logic          w_accept;
   logic          w_empty;
   logic          w_in_range;
   logic          w_hit;
   logic [SW-1:0] w_next_set;
   logic [EW-1:0] w_next_entry;
   logic [2:0]    w_adv_state;
   logic          w_unused_offsets;

   assign w_req_start_vpn = bus.req_va_start_i[VA_WIDTH-1:PAGE_BITS];
   assign w_req_end_vpn   = bus.req_va_end_i[VA_WIDTH-1:PAGE_BITS];
   assign w_unused_offsets = ^{bus.req_va_start_i[PAGE_BITS-1:0], bus.req_va_end_i[PAGE_BITS-1:0]};

   assign w_accept   = bus.req_valid_i & (r_state == S_IDLE);
   assign w_empty    = !bus.req_all_i && (w_req_start_vpn > w_req_end_vpn);
   assign w_in_range = (bus.tbl_rd_vpn_i >= r_start_vpn) && (bus.tbl_rd_vpn_i <= r_end_vpn);
   assign w_hit      = bus.tbl_rd_valid_i & (r_all | w_in_range);

   // Address step shared by the no-hit CHECK path and a granted CLEAR.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_entry = r_entry + 1'b1;
      w_next_set   = r_set;
      w_adv_state  = S_READ;
      if (r_entry == LAST_ENTRY) begin
         w_next_entry = '0;
         if (r_set == LAST_SET) begin
            w_next_set  = '0;
            w_adv_state = S_DONE;
         end else begin
            w_next_set = r_set + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_port      <= '0;
         r_all       <= 1'b0;
         r_start_vpn <= '0;
         r_end_vpn   <= '0;
         r_set       <= '0;
         r_entry     <= '0;
         r_count     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_port      <= bus.req_port_i;
                  r_all       <= bus.req_all_i;
                  r_start_vpn <= w_req_start_vpn;
                  r_end_vpn   <= w_req_end_vpn;
                  r_set       <= '0;
                  r_entry     <= '0;
                  r_count     <= '0;
                  r_state     <= w_empty ? S_DONE : S_READ;
               end
            end
            S_READ: begin
               if (bus.tbl_gnt_i) r_state <= S_CHECK;
            end
            S_CHECK: begin
               if (w_hit) begin
                  r_state <= S_CLEAR;
               end else begin
                  r_set   <= w_next_set;
                  r_entry <= w_next_entry;
                  r_state <= w_adv_state;
               end
            end
            S_CLEAR: begin
               if (bus.tbl_gnt_i) begin
                  r_count <= r_count + 1'b1;
                  r_set   <= w_next_set;
                  r_entry <= w_next_entry;
                  r_state <= w_adv_state;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign bus.req_ready_o = (r_state == S_IDLE);
   assign bus.busy_o      = (r_state == S_READ) || (r_state == S_CHECK) || (r_state == S_CLEAR);
   assign bus.done_o      = (r_state == S_DONE);
   assign bus.tbl_rd_en_o = (r_state == S_READ);
   assign bus.tbl_wr_en_o = (r_state == S_CLEAR);
   assign bus.inv_count_o = r_count;
   assign bus.tbl_port_o  = r_port;
   assign bus.tbl_set_o   = r_set;
   assign bus.tbl_entry_o = r_entry;
endmodule

// File: tb/tb_rab_inv_walker.sv
// Self-checking bench for rab_inv_walker: table vectors, hand-written corner
// sequences and randomized requests against a set-based reference model.
module tb_rab_inv_walker;
   localparam int N_PORTS   = 2;
   localparam int N_SETS    = 4;
   localparam int N_ENTRIES = 2;
   localparam int VA_WIDTH  = 32;
   localparam int PAGE_BITS = 12;
   localparam int VW        = VA_WIDTH - PAGE_BITS;
   localparam int NSE       = N_SETS * N_ENTRIES;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rab_inv_walker_if #(
      .N_PORTS(N_PORTS), .N_SETS(N_SETS), .N_ENTRIES(N_ENTRIES),
      .VA_WIDTH(VA_WIDTH), .PAGE_BITS(PAGE_BITS)
   ) bus ();

   rab_inv_walker #(
      .N_PORTS(N_PORTS), .N_SETS(N_SETS), .N_ENTRIES(N_ENTRIES),
      .VA_WIDTH(VA_WIDTH), .PAGE_BITS(PAGE_BITS)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Table contents as seen by the model and served to the walker.
   logic           t_valid [N_PORTS][N_SETS][N_ENTRIES];
   logic [VW-1:0]  t_vpn   [N_PORTS][N_SETS][N_ENTRIES];

   logic [NSE-1:0] exp_bits;
   logic [NSE-1:0] wr_bits;
   int             exp_hits;
   bit             exp_empty;
   int             n_wr;
   int             n_rd_gnt;
   int             n_denied;
   int             cur_port;
   bit             stall_mode;

   typedef struct {
      int          port;
      bit          all;
      logic [31:0] va_s;
      logic [31:0] va_e;
      bit          stall;
      int          exp_cnt;
      int          exp_lat;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_default();
      for (int p = 0; p < N_PORTS; p++)
         for (int s = 0; s < N_SETS; s++)
            for (int e = 0; e < N_ENTRIES; e++) begin
               t_valid[p][s][e] = 1'b0;
               t_vpn[p][s][e]   = VW'(3);
            end
      t_valid[1][0][0] = 1'b1; t_vpn[1][0][0] = VW'(2);
      t_valid[1][0][1] = 1'b1; t_vpn[1][0][1] = VW'(3);
      t_valid[1][1][0] = 1'b1; t_vpn[1][1][0] = VW'(4);
      t_valid[1][1][1] = 1'b1; t_vpn[1][1][1] = VW'(5);
      t_valid[1][2][0] = 1'b0; t_vpn[1][2][0] = VW'(4);
      t_valid[1][3][1] = 1'b1; t_vpn[1][3][1] = VW'('h100);
      t_valid[0][0][0] = 1'b1; t_vpn[0][0][0] = VW'(3);
      t_valid[0][3][1] = 1'b1; t_vpn[0][3][1] = VW'(4);
      t_valid[0][2][0] = 1'b1; t_vpn[0][2][0] = VW'('hFFFFF);
   endtask

   task automatic load_random();
      for (int p = 0; p < N_PORTS; p++)
         for (int s = 0; s < N_SETS; s++)
            for (int e = 0; e < N_ENTRIES; e++) begin
               t_valid[p][s][e] = 1'($urandom_range(0, 1));
               t_vpn[p][s][e]   = ($urandom_range(0, 7) == 0) ? VW'($urandom) : VW'($urandom_range(0, 15));
            end
   endtask

   // Reference: the set of valid entries whose page lies in [start, end].
   task automatic model(input int port, input bit all, input logic [31:0] vs, input logic [31:0] ve);
      logic [VW-1:0] svpn;
      logic [VW-1:0] evpn;
      svpn = vs[31:PAGE_BITS];
      evpn = ve[31:PAGE_BITS];
      exp_empty = !all && (svpn > evpn);
      exp_bits  = '0;
      exp_hits  = 0;
      if (!exp_empty)
         for (int s = 0; s < N_SETS; s++)
            for (int e = 0; e < N_ENTRIES; e++)
               if (t_valid[port][s][e] && (all || (t_vpn[port][s][e] >= svpn && t_vpn[port][s][e] <= evpn))) begin
                  exp_bits[s*N_ENTRIES+e] = 1'b1;
                  exp_hits++;
               end
   endtask

   // Table responder and protocol monitor, active on the falling edge.
   initial begin : table_side
      bit       prev_rd_gnt;
      bit       prev_active;
      bit       prev_gnt;
      logic [7:0] prev_addr;
      logic     prev_rd;
      logic     prev_wr;
      int       pp, ps, pe;
      prev_rd_gnt = 0; prev_active = 0; prev_gnt = 1; prev_addr = '0;
      prev_rd = 0; prev_wr = 0; pp = 0; ps = 0; pe = 0;
      bus.tbl_gnt_i = 1'b1;
      bus.tbl_rd_valid_i = 1'b0;
      bus.tbl_rd_vpn_i = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rd_gnt = 0;
            prev_active = 0;
            continue;
         end
         if (prev_rd_gnt) begin
            bus.tbl_rd_valid_i = t_valid[pp][ps][pe];
            bus.tbl_rd_vpn_i   = t_vpn[pp][ps][pe];
         end else begin
            bus.tbl_rd_valid_i = 1'($urandom_range(0, 1));
            bus.tbl_rd_vpn_i   = VW'($urandom_range(0, 15));
         end
         bus.tbl_gnt_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.tbl_rd_en_o || bus.tbl_wr_en_o) begin
            check("rd_wr_exclusive", {bus.tbl_rd_en_o, bus.tbl_wr_en_o}, (bus.tbl_rd_en_o ? 2'b10 : 2'b01));
            check("tbl_port", bus.tbl_port_o, cur_port);
         end
         if (prev_active && !prev_gnt) begin
            check("stall_addr_stable", {bus.tbl_port_o, bus.tbl_set_o, bus.tbl_entry_o}, prev_addr);
            check("stall_cmd_stable", {bus.tbl_rd_en_o, bus.tbl_wr_en_o}, {prev_rd, prev_wr});
         end
         if ((bus.tbl_rd_en_o || bus.tbl_wr_en_o) && !bus.tbl_gnt_i) n_denied++;
         if (bus.tbl_rd_en_o && bus.tbl_gnt_i) n_rd_gnt++;
         if (bus.tbl_wr_en_o && bus.tbl_gnt_i) begin
            n_wr++;
            wr_bits[int'(bus.tbl_set_o)*N_ENTRIES + int'(bus.tbl_entry_o)] = 1'b1;
            t_valid[bus.tbl_port_o][bus.tbl_set_o][bus.tbl_entry_o] = 1'b0;
         end
         prev_rd_gnt = bus.tbl_rd_en_o && bus.tbl_gnt_i;
         pp = int'(bus.tbl_port_o);
         ps = int'(bus.tbl_set_o);
         pe = int'(bus.tbl_entry_o);
         prev_active = bus.tbl_rd_en_o || bus.tbl_wr_en_o;
         prev_gnt    = bus.tbl_gnt_i;
         prev_rd     = bus.tbl_rd_en_o;
         prev_wr     = bus.tbl_wr_en_o;
         prev_addr   = 8'({bus.tbl_port_o, bus.tbl_set_o, bus.tbl_entry_o});
      end
   end

   task automatic wait_ready();
      int w;
      @(negedge clk);
      w = 0;
      while (!bus.req_ready_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_req", bus.req_ready_o, 1);
   endtask

   task automatic drive_req(input int port, input bit all, input logic [31:0] vs, input logic [31:0] ve);
      bus.req_port_i     = 1'(port);
      bus.req_all_i      = all;
      bus.req_va_start_i = vs;
      bus.req_va_end_i   = ve;
      bus.req_valid_i    = 1'b1;
   endtask

   task automatic do_req(input int port, input bit all, input logic [31:0] vs, input logic [31:0] ve,
                         input bit stall, output int lat);
      model(port, all, vs, ve);
      wait_ready();
      n_wr = 0; n_rd_gnt = 0; n_denied = 0; wr_bits = '0;
      cur_port = port;
      stall_mode = stall;
      drive_req(port, all, vs, ve);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i    = 1'b0;
      bus.req_va_start_i = $urandom;
      bus.req_all_i      = 1'($urandom_range(0, 1));
      lat = 1;
      while (!bus.done_o && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", bus.done_o, 1);
      check("inv_count", bus.inv_count_o, exp_hits);
      check("write_count", n_wr, exp_hits);
      check("write_set", wr_bits, exp_bits);
      check("latency", lat - n_denied, exp_empty ? 1 : 2*NSE + exp_hits + 1);
      check("granted_reads", n_rd_gnt, exp_empty ? 0 : NSE);
      check("ready_in_done", bus.req_ready_o, 0);
      @(negedge clk);
      check("done_pulse_1cyc", bus.done_o, 0);
      check("ready_after_done", bus.req_ready_o, 1);
      check("count_holds", bus.inv_count_o, exp_hits);
      stall_mode = 0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int lat;
      int w;
      bus.req_valid_i = 1'b0;
      bus.req_port_i = '0;
      bus.req_all_i = 1'b0;
      bus.req_va_start_i = '0;
      bus.req_va_end_i = '0;
      stall_mode = 0;
      cur_port = 0;
      load_default();

      vecs[0] = '{1, 1'b0, 32'h0000_3000, 32'h0000_4FFF, 1'b0, 2, 19};
      vecs[1] = '{1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 5, 22};
      vecs[2] = '{1, 1'b0, 32'h0000_5000, 32'h0000_4000, 1'b0, 0, 1};
      vecs[3] = '{0, 1'b0, 32'h0000_3000, 32'h0000_4FFF, 1'b0, 2, 19};
      vecs[4] = '{1, 1'b0, 32'h0000_3ABC, 32'h0000_3001, 1'b0, 1, 18};
      vecs[5] = '{1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 5, 22};
      vecs[6] = '{1, 1'b0, 32'h0000_3000, 32'h0000_4FFF, 1'b1, 2, 19};
      vecs[7] = '{1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 5, 22};
      vecs[8] = '{1, 1'b0, 32'h0010_0000, 32'h0010_0FFF, 1'b0, 1, 18};

      // Reset values, both while held and after release.
      repeat (3) @(negedge clk);
      check("rst_ready", bus.req_ready_o, 1);
      check("rst_strobes", {bus.busy_o, bus.done_o, bus.tbl_rd_en_o, bus.tbl_wr_en_o}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", bus.req_ready_o, 1);
      check("post_rst_strobes", {bus.busy_o, bus.done_o, bus.tbl_rd_en_o, bus.tbl_wr_en_o}, 0);
      check("post_rst_count", bus.inv_count_o, 0);
      check("post_rst_addr", {bus.tbl_port_o, bus.tbl_set_o, bus.tbl_entry_o}, 0);

      for (int i = 0; i < 9; i++) begin
         load_default();
         do_req(vecs[i].port, vecs[i].all, vecs[i].va_s, vecs[i].va_e, vecs[i].stall, lat);
         check("vec_count", bus.inv_count_o, vecs[i].exp_cnt);
         check("vec_latency", lat - n_denied, vecs[i].exp_lat);
      end

      // Asynchronous reset while a CLEAR is being presented.
      load_default();
      wait_ready();
      cur_port = 1;
      drive_req(1, 1'b0, 32'h0000_3000, 32'h0000_4FFF);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      w = 0;
      while (!bus.tbl_wr_en_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("reached_clear", bus.tbl_wr_en_o, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_wr_en", bus.tbl_wr_en_o, 0);
      check("rst_mid_ready", bus.req_ready_o, 1);
      check("rst_mid_busy", bus.busy_o, 0);
      check("rst_mid_count", bus.inv_count_o, 0);
      check("rst_mid_addr", {bus.tbl_port_o, bus.tbl_set_o, bus.tbl_entry_o}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_mid_quiet", {bus.tbl_rd_en_o, bus.tbl_wr_en_o, bus.busy_o}, 0);
      end

      // Back-to-back: a flush held valid during a range walk waits for IDLE.
      load_default();
      wait_ready();
      cur_port = 1;
      drive_req(1, 1'b0, 32'h0000_3000, 32'h0000_4FFF);
      @(posedge clk);
      @(negedge clk);
      drive_req(1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
      w = 0;
      while (!bus.done_o && w < 200) begin
         check("b2b_not_ready", bus.req_ready_o, 0);
         @(negedge clk);
         w++;
      end
      check("b2b_first_done", bus.done_o, 1);
      check("b2b_first_count", bus.inv_count_o, 2);
      @(negedge clk);
      check("b2b_ready_after_done", bus.req_ready_o, 1);
      check("b2b_count_held", bus.inv_count_o, 2);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      check("b2b_accepted", bus.busy_o, 1);
      check("b2b_count_cleared", bus.inv_count_o, 0);
      w = 0;
      while (!bus.done_o && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("b2b_second_done", bus.done_o, 1);
      check("b2b_second_count", bus.inv_count_o, 3);

      // Randomized requests against the model.
      for (int r = 0; r < 25; r++) begin
         int          port;
         bit          all;
         logic [31:0] vs;
         logic [31:0] ve;
         load_random();
         port = $urandom_range(0, N_PORTS - 1);
         all  = ($urandom_range(0, 3) == 0);
         vs   = {20'($urandom_range(0, 15)), 12'($urandom)};
         ve   = {20'($urandom_range(0, 15)), 12'($urandom)};
         do_req(port, all, vs, ve, 1'($urandom_range(0, 1)), lat);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
